// File: rtl/rd_wait_pkg.sv
// Shared types and default widths for the wait-state read slave.
package rd_wait_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;
    localparam int WW_DEF = 4;
    localparam int TXN_W  = 16;

    // Encoding 3 is unused; the FSM falls back to IDLE if it ever appears.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/rd_wait_slave_if.sv
// Bus bundle between the read-handshake master/host and the wait-state slave.
interface rd_wait_slave_if
    import rd_wait_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int WW = WW_DEF
);
    logic             rd;
    logic [AW-1:0]    addr;
    logic [WW-1:0]    wait_cfg;
    logic             ws;
    logic [DW-1:0]    rdata;
    logic             rvalid;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [TXN_W-1:0] txn_cnt;
    logic             abort_err;
    logic             err_clr;

    modport master (
        output rd, addr, wait_cfg, we, waddr, wdata, err_clr,
        input  ws, rdata, rvalid, txn_cnt, abort_err
    );

    modport slave (
        input  rd, addr, wait_cfg, we, waddr, wdata, err_clr,
        output ws, rdata, rvalid, txn_cnt, abort_err
    );
endinterface

// File: rtl/rd_wait_mem.sv
// 1W/1R synchronous RAM; registered read returns pre-write data on a same-address collision.
module rd_wait_mem #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds the last loaded word until the next read load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/rd_wait_slave.sv
// Read slave: programmable wait states, one-word response, transaction counter and abort flag.
module rd_wait_slave
    import rd_wait_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int WW = WW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    rd_wait_slave_if.slave bus
);

    state_t           state_q, state_d;
    logic [WW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    load_addr;
    logic             load;
    logic             set_abort;
    logic             txn_inc;
    logic             rvalid_q;
    logic             abort_q;
    logic [TXN_W-1:0] txn_q;
    logic [DW-1:0]    rdata_w;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            txn_q    <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= load;
            if (txn_inc) begin
                txn_q <= txn_q + TXN_W'(1);
            end
            if (set_abort) begin
                abort_q <= 1'b1;
            end else if (bus.err_clr) begin
                abort_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.rd) begin
            addr_q <= bus.addr;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_addr = addr_q;
        set_abort = 1'b0;
        txn_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd) begin
                    cnt_d = bus.wait_cfg;
                    if (bus.wait_cfg == '0) begin
                        state_d   = READY;
                        load      = 1'b1;
                        load_addr = bus.addr;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.rd) begin
                    state_d   = IDLE;
                    set_abort = 1'b1;
                end else begin
                    // WAIT is only entered with cnt >= 1, so this never wraps.
                    cnt_d = cnt_q - WW'(1);
                    if (cnt_q == WW'(1)) begin
                        state_d = READY;
                        load    = 1'b1;
                    end
                end
            end
            READY: begin
                if (!bus.rd) begin
                    state_d = IDLE;
                    txn_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    rd_wait_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.we),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .re    (load),
        .raddr (load_addr),
        .rdata (rdata_w)
    );

    assign bus.ws        = (state_q == WAIT);
    assign bus.rdata     = rdata_w;
    assign bus.rvalid    = rvalid_q;
    assign bus.txn_cnt   = txn_q;
    assign bus.abort_err = abort_q;

endmodule

// File: tb/tb_rd_wait_slave.sv
// Self-checking bench for rd_wait_slave: directed scenarios plus randomized reads against a cycle-count model.
module tb_rd_wait_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rd_wait_slave_if #(.DW(8), .AW(4), .WW(4)) bus ();

    rd_wait_slave #(.DW(8), .AW(4), .WW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  mem_model [16];
    logic [15:0] exp_txn = 16'd0;
    logic [7:0]  last_rdata = 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        tick();
        mem_model[a] = d;
        bus.we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.rd = 1'b1; bus.addr = 4'd0; bus.wait_cfg = 4'd0;
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.err_clr = 1'b0;
        tick(); tick();
        checks++; if (bus.ws !== 1'b0) begin errors++; $display("FAIL reset_ws got=%b exp=0", bus.ws); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); end
        checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
        checks++; if (bus.txn_cnt !== 16'd0) begin errors++; $display("FAIL reset_txn got=%0d exp=0", bus.txn_cnt); end
        checks++; if (bus.abort_err !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", bus.abort_err); end
        rst = 1'b1; bus.rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.ws !== 1'b0 || bus.rvalid !== 1'b0) begin
                errors++; $display("FAIL idle_after_reset ws=%b rvalid=%b exp 0/0", bus.ws, bus.rvalid);
            end
        end
        exp_txn = 16'd0; last_rdata = 8'h00;
        for (int i = 0; i < 16; i++) host_write(4'(i), 8'($urandom));
    endtask

    task automatic test_zero_wait();
        host_write(4'd3, 8'hA5);
        bus.wait_cfg = 4'd0; bus.addr = 4'd3; bus.rd = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            bus.addr = 4'd9; bus.wait_cfg = 4'd6;
            checks++; if (bus.ws !== 1'b0) begin errors++; $display("FAIL zw_ws k=%0d got=%b exp=0", k, bus.ws); end
            checks++; if (bus.rvalid !== (k == 1)) begin errors++; $display("FAIL zw_rvalid k=%0d got=%b exp=%b", k, bus.rvalid, k == 1); end
            checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL zw_rdata k=%0d got=%h exp=a5", k, bus.rdata); end
        end
        bus.rd = 1'b0;
        tick();
        exp_txn++; last_rdata = 8'hA5;
        checks++; if (bus.txn_cnt !== exp_txn) begin errors++; $display("FAIL zw_txn got=%0d exp=%0d", bus.txn_cnt, exp_txn); end
    endtask

    // Upstream master behaviour: hold rd while ws=1, finish (ds) once data arrives with ws low.
    task automatic test_wait_upstream();
        int ws_cycles = 0;
        int rv_cycle = -1;
        logic ds = 1'b0;
        logic [7:0] got = 8'h00;
        host_write(4'd7, 8'h3C);
        bus.wait_cfg = 4'd3; bus.addr = 4'd7; bus.rd = 1'b1;
        for (int k = 1; k <= 40 && !ds; k++) begin
            tick();
            bus.addr = 4'($urandom); bus.wait_cfg = 4'($urandom);
            if (bus.ws === 1'b1) ws_cycles++;
            if (bus.rvalid === 1'b1) begin rv_cycle = k; got = bus.rdata; end
            if (bus.ws === 1'b0 && rv_cycle > 0) begin ds = 1'b1; bus.rd = 1'b0; end
        end
        checks++; if (!ds) begin errors++; $display("FAIL up_done ds=%b exp=1 (timeout)", ds); end
        checks++; if (ws_cycles != 3) begin errors++; $display("FAIL up_ws_cycles got=%0d exp=3", ws_cycles); end
        checks++; if (rv_cycle != 4) begin errors++; $display("FAIL up_rvalid_cycle got=%0d exp=4", rv_cycle); end
        checks++; if (got !== 8'h3C) begin errors++; $display("FAIL up_rdata got=%h exp=3c", got); end
        bus.rd = 1'b0;
        tick();
        exp_txn++; last_rdata = 8'h3C;
        checks++; if (bus.txn_cnt !== exp_txn) begin errors++; $display("FAIL up_txn got=%0d exp=%0d", bus.txn_cnt, exp_txn); end
    endtask

    task automatic test_abort();
        logic saw_rv = 1'b0;
        bus.wait_cfg = 4'd5; bus.addr = 4'd1; bus.rd = 1'b1;
        tick(); if (bus.rvalid === 1'b1) saw_rv = 1'b1;
        tick(); if (bus.rvalid === 1'b1) saw_rv = 1'b1;
        bus.rd = 1'b0;
        tick(); if (bus.rvalid === 1'b1) saw_rv = 1'b1;
        checks++; if (bus.abort_err !== 1'b1) begin errors++; $display("FAIL abort_set got=%b exp=1", bus.abort_err); end
        checks++; if (saw_rv) begin errors++; $display("FAIL abort_rvalid got=1 exp=0"); end
        checks++; if (bus.txn_cnt !== exp_txn) begin errors++; $display("FAIL abort_txn got=%0d exp=%0d", bus.txn_cnt, exp_txn); end
        checks++; if (bus.rdata !== last_rdata) begin errors++; $display("FAIL abort_rdata got=%h exp=%h", bus.rdata, last_rdata); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.abort_err !== 1'b0) begin errors++; $display("FAIL abort_clr got=%b exp=0", bus.abort_err); end
        // Set beats clear on the same edge.
        bus.wait_cfg = 4'd2; bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0; bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.abort_err !== 1'b1) begin errors++; $display("FAIL abort_set_vs_clr got=%b exp=1", bus.abort_err); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_collision();
        host_write(4'd2, 8'h11);
        bus.wait_cfg = 4'd0; bus.addr = 4'd2; bus.rd = 1'b1;
        bus.we = 1'b1; bus.waddr = 4'd2; bus.wdata = 8'h22;
        tick();
        bus.we = 1'b0; mem_model[2] = 8'h22;
        checks++; if (bus.rdata !== 8'h11 || bus.rvalid !== 1'b1) begin
            errors++; $display("FAIL coll_old rdata=%h rvalid=%b exp=11/1", bus.rdata, bus.rvalid);
        end
        bus.rd = 1'b0; tick(); exp_txn++;
        bus.rd = 1'b1; tick();
        checks++; if (bus.rdata !== 8'h22) begin errors++; $display("FAIL coll_new got=%h exp=22", bus.rdata); end
        bus.rd = 1'b0; tick(); exp_txn++; last_rdata = 8'h22;
        checks++; if (bus.txn_cnt !== exp_txn) begin errors++; $display("FAIL coll_txn got=%0d exp=%0d", bus.txn_cnt, exp_txn); end
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] a;
        bus.wait_cfg = 4'd7; bus.addr = 4'd5; bus.rd = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus.ws !== 1'b1) begin errors++; $display("FAIL rmw_ws_before got=%b exp=1", bus.ws); end
        rst = 1'b0;
        tick();
        checks++; if (bus.ws !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL rmw_idle ws=%b rvalid=%b exp 0/0", bus.ws, bus.rvalid); end
        checks++; if (bus.txn_cnt !== 16'd0 || bus.rdata !== 8'h00) begin errors++; $display("FAIL rmw_regs txn=%0d rdata=%h exp 0/00", bus.txn_cnt, bus.rdata); end
        rst = 1'b1; bus.rd = 1'b0; exp_txn = 16'd0;
        tick();
        a = 4'($urandom);
        bus.wait_cfg = 4'd1; bus.addr = a; bus.rd = 1'b1;
        tick();
        checks++; if (bus.ws !== 1'b1 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL rmw_new_wait ws=%b rvalid=%b exp 1/0", bus.ws, bus.rvalid); end
        tick();
        checks++; if (bus.ws !== 1'b0 || bus.rvalid !== 1'b1 || bus.rdata !== mem_model[a]) begin
            errors++; $display("FAIL rmw_new_data ws=%b rvalid=%b rdata=%h exp 0/1/%h", bus.ws, bus.rvalid, bus.rdata, mem_model[a]);
        end
        last_rdata = mem_model[a];
        bus.rd = 1'b0; tick(); exp_txn++;
        checks++; if (bus.txn_cnt !== exp_txn) begin errors++; $display("FAIL rmw_txn got=%0d exp=%0d", bus.txn_cnt, exp_txn); end
    endtask

    // Model: after the edge that first samples rd, ws is high for w cycles, data lands at cycle w+1.
    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [3:0] a = 4'($urandom);
            int w = $urandom_range(0, 6);
            logic abrt = (w > 0) && ($urandom_range(0, 3) == 0);
            int n = abrt ? $urandom_range(1, w) : w + 1 + $urandom_range(0, 2);
            logic [7:0] exp_data = 8'h00;
            for (int j = 0; j <= n; j++) begin
                logic do_we = ($urandom_range(0, 2) == 0);
                logic [3:0] wa = 4'($urandom);
                logic [7:0] wd = 8'($urandom);
                bus.rd = (j < n);
                bus.addr = (j == 0) ? a : 4'($urandom);
                bus.wait_cfg = (j == 0) ? 4'(w) : 4'($urandom);
                bus.we = do_we; bus.waddr = wa; bus.wdata = wd;
                if (j == w && !abrt) exp_data = mem_model[a];
                tick();
                if (do_we) mem_model[wa] = wd;
                if (j < n) begin
                    checks++; if (bus.ws !== (j < w)) begin errors++; $display("FAIL rnd_ws t=%0d j=%0d got=%b exp=%b", t, j, bus.ws, j < w); end
                    checks++; if (bus.rvalid !== (j == w)) begin errors++; $display("FAIL rnd_rvalid t=%0d j=%0d got=%b exp=%b", t, j, bus.rvalid, j == w); end
                    if (j >= w) begin
                        checks++; if (bus.rdata !== exp_data) begin errors++; $display("FAIL rnd_rdata t=%0d j=%0d got=%h exp=%h", t, j, bus.rdata, exp_data); end
                    end
                end
            end
            bus.we = 1'b0;
            if (!abrt) begin exp_txn++; last_rdata = exp_data; end
            checks++; if (bus.ws !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL rnd_end t=%0d ws=%b rvalid=%b exp 0/0", t, bus.ws, bus.rvalid); end
            checks++; if (bus.txn_cnt !== exp_txn) begin errors++; $display("FAIL rnd_txn t=%0d got=%0d exp=%0d", t, bus.txn_cnt, exp_txn); end
            checks++; if (bus.abort_err !== abrt) begin errors++; $display("FAIL rnd_abort t=%0d got=%b exp=%b", t, bus.abort_err, abrt); end
            checks++; if (bus.rdata !== last_rdata) begin errors++; $display("FAIL rnd_hold t=%0d got=%h exp=%h", t, bus.rdata, last_rdata); end
            if (abrt) begin
                bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_upstream();
        test_abort();
        test_collision();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
